// File: rtl/bus_master_pkg.sv
// bus_master_pkg: FSM state encoding and default widths/timeout shared by the Wishbone master
package bus_master_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } state_t;
  localparam int ADR_WIDTH_DEF = 16;
  localparam int DAT_WIDTH_DEF = 64;
  localparam int TIMEOUT_DEF   = 255;
endpackage

// File: rtl/bus_master.sv
// bus_master: single-transaction Wishbone classic master with err/timeout reporting
//   clk_i, rst_i (async, active low)
//   req_*  : client request (valid/ready handshake, we, adr, dat)
//   rsp_*  : one-cycle response strobe with data, err and timeout flags
//   m_*    : Wishbone master port (cyc, stb, we, adr, dat out; dat, ack, err in)
module bus_master
  import bus_master_pkg::*;
#(
  parameter int ADR_WIDTH = ADR_WIDTH_DEF,
  parameter int DAT_WIDTH = DAT_WIDTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADR_WIDTH-1:0] req_adr_i,
  input  logic [DAT_WIDTH-1:0] req_dat_i,
  output logic                 rsp_valid_o,
  output logic [DAT_WIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [ADR_WIDTH-1:0] m_adr_o,
  output logic [DAT_WIDTH-1:0] m_dat_o,
  input  logic [DAT_WIDTH-1:0] m_dat_i,
  input  logic                 m_ack_i,
  input  logic                 m_err_i
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic cyc_d, stb_d, we_d, rsp_valid_d, rsp_err_d, rsp_to_d, to_hit;
  logic [ADR_WIDTH-1:0] adr_d;
  logic [DAT_WIDTH-1:0] dat_d, rsp_dat_d;
  assign req_ready_o = state == IDLE;
  // a zero TIMEOUT disables the abort entirely
  assign to_hit = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cyc_d       = m_cyc_o;
    stb_d       = m_stb_o;
    we_d        = m_we_o;
    adr_d       = m_adr_o;
    dat_d       = m_dat_o;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;
    rsp_dat_d   = rsp_dat_o;
    case (state)
      IDLE: if (req_valid_i) begin
        state_d = ACTIVE;
        adr_d   = req_adr_i;
        we_d    = req_we_i;
        dat_d   = req_we_i ? req_dat_i : '0;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        cnt_d   = '0;
      end
      ACTIVE: if (m_err_i || m_ack_i || to_hit) begin
        state_d     = RELEASE;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = m_err_i;
        rsp_to_d    = !m_err_i && !m_ack_i;
        // err outranks ack; only a clean read ack returns slave data
        rsp_dat_d   = (m_ack_i && !m_err_i && !m_we_o) ? m_dat_i : '0;
      end else begin
        cnt_d = cnt == CW'(TIMEOUT) ? cnt : cnt + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      m_cyc_o       <= 1'b0;
      m_stb_o       <= 1'b0;
      m_we_o        <= 1'b0;
      m_adr_o       <= '0;
      m_dat_o       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      rsp_dat_o     <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      m_cyc_o       <= cyc_d;
      m_stb_o       <= stb_d;
      m_we_o        <= we_d;
      m_adr_o       <= adr_d;
      m_dat_o       <= dat_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_err_o     <= rsp_err_d;
      rsp_timeout_o <= rsp_to_d;
      rsp_dat_o     <= rsp_dat_d;
    end
  end
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: vector table plus scoreboard against a registered instruction-ROM slave
module tb_bus_master;
  logic clk_i = 1'b0;
  logic rst_i;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic req_valid_i, req_ready_o, req_we_i;
  logic [15:0] req_adr_i;
  logic [63:0] req_dat_i;
  logic rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [63:0] rsp_dat_o;
  logic m_cyc_o, m_stb_o, m_we_o, s_ack, s_err;
  logic [15:0] m_adr_o;
  logic [63:0] m_dat_o, s_dat;
  logic both_mode;
  logic t_valid, t_ready, t_rsp_valid, t_err, t_to, t_cyc, t_stb, t_we;
  logic [15:0] t_adr, t_madr;
  logic [63:0] t_rsp_dat, t_mdat;
  logic [63:0] zero64 = '0;
  logic zero1 = 1'b0;

  bus_master dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_dat_i(s_dat), .m_ack_i(s_ack), .m_err_i(s_err)
  );

  bus_master #(.TIMEOUT(8)) dut_to (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(t_valid), .req_ready_o(t_ready), .req_we_i(zero1),
    .req_adr_i(t_adr), .req_dat_i(zero64),
    .rsp_valid_o(t_rsp_valid), .rsp_dat_o(t_rsp_dat), .rsp_err_o(t_err),
    .rsp_timeout_o(t_to),
    .m_cyc_o(t_cyc), .m_stb_o(t_stb), .m_we_o(t_we), .m_adr_o(t_madr),
    .m_dat_o(t_mdat), .m_dat_i(zero64), .m_ack_i(zero1), .m_err_i(zero1)
  );

  initial forever #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [63:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: return 64'h0287800010001018;
      16'h0018: return 64'h02804000000002a0;
      16'h0028: return 64'h028680000004e200;
      default:  return 64'hfe00000000000000;
    endcase
  endfunction

  // registered ROM: acks reads, errs writes, one cycle after stb; both_mode raises both
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      s_dat <= '0;
    end else begin
      s_ack <= m_cyc_o & m_stb_o & !s_ack & !s_err & (!m_we_o | both_mode);
      s_err <= m_cyc_o & m_stb_o & !s_ack & !s_err & (m_we_o | both_mode);
      s_dat <= rom(m_adr_o);
    end
  end

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [63:0] dat;
    logic [63:0] exp_dat;
    logic        exp_err;
    logic        exp_to;
  } vec_t;
  typedef struct {
    logic [63:0] dat;
    logic        err;
    logic        to;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [15:0] adr, input logic [63:0] dat,
                     input logic [63:0] ed, input logic ee, input logic et, output int acc);
    exp_t e;
    for (int n = 0; n < 20 && !req_ready_o; n++) @(negedge clk_i);
    check("ready_before_req", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_adr_i   = adr;
    req_dat_i   = dat;
    @(posedge clk_i);
    #1;
    acc = cyc;
    req_valid_i = 1'b0;
    req_adr_i   = 16'hffff;
    sb.push_back('{ed, ee, et, acc + 2});
    check("bus_ctl_cycle1", {m_cyc_o, m_stb_o, m_we_o, req_ready_o}, {1'b1, 1'b1, we, 1'b0});
    check("bus_adr_cycle1", m_adr_o, adr);
    check("bus_dat_cycle1", m_dat_o, we ? dat : 64'h0);
    @(negedge clk_i);
    for (int n = 0; n < 20 && !rsp_valid_o; n++) @(negedge clk_i);
    e = sb.pop_front();
    check("rsp_valid_seen", rsp_valid_o, 1'b1);
    check("rsp_cycle", cyc, e.cyc);
    check("rsp_dat", rsp_dat_o, e.dat);
    check("rsp_err_to", {rsp_err_o, rsp_timeout_o, m_stb_o}, {e.err, e.to, 1'b0});
    @(negedge clk_i);
    check("ready_after_rsp", {req_ready_o, rsp_valid_o, rsp_dat_o}, {1'b1, 1'b0, e.dat});
  endtask

  vec_t vecs[5];
  int acc, prev;

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 64'h0, 64'h0287800010001018, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0100, 64'h0, 64'hfe00000000000000, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0008, 64'h1234, 64'h0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'h0018, 64'h0, 64'h02804000000002a0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h0028, 64'h0, 64'h028680000004e200, 1'b0, 1'b0};
    rst_i = 1'b0;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_adr_i = '0;
    req_dat_i = '0;
    both_mode = 1'b0;
    t_valid = 1'b0;
    t_adr = '0;
    repeat (3) @(negedge clk_i);
    check("reset_ctl", {m_cyc_o, m_stb_o, m_we_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, req_ready_o},
          7'b0000001);
    check("reset_data", {m_adr_o, m_dat_o, rsp_dat_o}, '0);
    rst_i = 1'b1;
    #1;
    check("ready_after_reset", req_ready_o, 1'b1);
    @(negedge clk_i);
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].exp_dat, vecs[i].exp_err, vecs[i].exp_to, acc);
      if (i > 0) check("throughput", acc - prev, 4);
      prev = acc;
    end
    both_mode = 1'b1;
    txn(1'b0, 16'h0000, 64'h0, 64'h0, 1'b1, 1'b0, acc);
    both_mode = 1'b0;
    txn(1'b0, 16'h0018, 64'h0, 64'h02804000000002a0, 1'b0, 1'b0, prev);
    req_valid_i = 1'b1;
    req_adr_i = 16'h0028;
    req_we_i = 1'b0;
    @(posedge clk_i);
    #1;
    acc = cyc;
    req_valid_i = 1'b0;
    check("b2b_accept_gap", acc - prev, 4);
    check("abort_stb_cycle1", m_stb_o, 1'b1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("abort_stb_drop", {m_cyc_o, m_stb_o, rsp_valid_o}, 3'b000);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("abort_ready", req_ready_o, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("abort_no_rsp", {rsp_valid_o, m_stb_o}, 2'b00);
    end
    t_valid = 1'b1;
    t_adr = 16'h0040;
    @(posedge clk_i);
    #1;
    acc = cyc;
    t_valid = 1'b0;
    check("to_stb_cycle1", {t_cyc, t_stb, t_ready}, 3'b110);
    @(negedge clk_i);
    for (int n = 0; n < 30 && !t_rsp_valid; n++) @(negedge clk_i);
    check("to_rsp_seen", t_rsp_valid, 1'b1);
    check("to_rsp_cycle", cyc, acc + 8);
    check("to_flags", {t_to, t_err, t_stb, t_cyc}, 4'b1000);
    check("to_dat", t_rsp_dat, 64'h0);
    @(negedge clk_i);
    check("to_ready_after", {t_ready, t_rsp_valid}, 2'b10);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 The block SHALL have parameter ADR_WIDTH, default 16, meaning the Wishbone address width in bits.
REQ-002 The block SHALL have parameter DAT_WIDTH, default `DAT_WIDTH (64), meaning the Wishbone data width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ACTIVE cycles without ack/err; 0 disables the timeout.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: clk_i  input  1  clock; rst_i  input  1  asynchronous active-low reset.
REQ-005 req_valid_i  input  1  client request present.
REQ-006 req_ready_o  output  1  block accepts a request this cycle.
REQ-007 req_we_i  input  1  1 = write, 0 = read.
REQ-008 req_adr_i  input  ADR_WIDTH  request address.
REQ-009 req_dat_i  input  DAT_WIDTH  write data.
REQ-010 rsp_valid_o  output  1  one-cycle response strobe.
REQ-011 rsp_dat_o  output  DAT_WIDTH  read data, valid with rsp_valid_o.
REQ-012 rsp_err_o  output  1  slave signalled err.
REQ-013 rsp_timeout_o  output  1  transaction aborted by timeout.
REQ-014 The Wishbone master port SHALL be: m_cyc_o, m_stb_o, m_we_o (output, 1); m_adr_o (output, ADR_WIDTH); m_dat_o (output, DAT_WIDTH); m_dat_i (input, DAT_WIDTH); m_ack_i, m_err_i (input, 1).

Function
REQ-015 FSM states SHALL be IDLE, ACTIVE and RELEASE.
REQ-016 req_ready_o SHALL be combinationally 1 exactly when state is IDLE.
REQ-017 On a clock edge with req_valid_i & req_ready_o: go to ACTIVE; register req_adr_i into m_adr_o, req_we_i into m_we_o, and req_dat_i into m_dat_o (m_dat_o = 0 for reads); set m_cyc_o = m_stb_o = 1; clear the timeout counter.
REQ-018 In ACTIVE, m_adr_o, m_we_o and m_dat_o SHALL be held stable, and m_cyc_o/m_stb_o SHALL stay 1.
REQ-019 ACTIVE with m_err_i = 1 sampled: rsp_err_o <= 1, rsp_dat_o <= 0, rsp_valid_o <= 1, go to RELEASE.
REQ-020 ACTIVE with m_ack_i = 1 sampled and m_err_i = 0: rsp_dat_o <= m_dat_i (reads) or 0 (writes), rsp_valid_o <= 1, go to RELEASE.
REQ-021 When ack and err are both 1, err SHALL take priority.
REQ-022 ACTIVE with neither ack nor err: counter increments, saturating at TIMEOUT.
REQ-023 On the edge where the counter equals TIMEOUT-1 (TIMEOUT ≠ 0): rsp_timeout_o <= 1, rsp_valid_o <= 1, rsp_dat_o <= 0, go to RELEASE.
REQ-024 Every transition into RELEASE SHALL drive m_cyc_o = m_stb_o = 0 in the same registered update.
REQ-025 RELEASE SHALL last exactly one cycle, during which the slave phase-end is guaranteed, then go to IDLE.
REQ-026 rsp_valid_o, rsp_err_o and rsp_timeout_o SHALL be high only during the RELEASE cycle.
REQ-027 rsp_dat_o SHALL hold its value until the next response.
REQ-028 Latency: accept at edge 0; m_stb_o high from cycle 1; with a slave acking at edge k, rsp_valid_o is high in cycle k+1 and req_ready_o is high in cycle k+2.
REQ-029 Against a registered slave that acks one cycle after stb, throughput SHALL be one transaction per 4 cycles.
REQ-030 m_ack_i/m_err_i SHALL be ignored in IDLE and RELEASE.
REQ-031 req_valid_i SHALL be ignored outside IDLE.

Reset
REQ-032 Asserting rst_i (low) SHALL asynchronously force IDLE and clear to 0: m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o and the counter.
REQ-033 Reset mid-transaction SHALL drop m_stb_o immediately and produce no response.
REQ-034 req_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Structure
REQ-035 FSM state encodings and the default TIMEOUT SHALL be defines in the shared Wishbone include; ADR/DAT widths SHALL come from the shared config include.
REQ-036 The block SHALL be a single module with no sub-module; the counter width SHALL be `CLOG2(TIMEOUT+1).

Verification
REQ-037 Read 0x0000 from the instruction ROM -> rsp_valid_o in cycle 3 with rsp_dat_o = 0x0287800010001018, err = timeout = 0, req_ready_o in cycle 4.
REQ-038 Read unmapped 0x0100 from the ROM -> rsp_dat_o = 0xfe00000000000000, err = 0.
REQ-039 Write 0x0008 with data 0x1234 to the ROM -> rsp_err_o = 1, rsp_dat_o = 0, the ROM's ack never seen.
REQ-040 No slave attached (ack = err = 0), TIMEOUT = 8 -> rsp_timeout_o = 1 at cycle 9, m_stb_o low in that cycle.
REQ-041 Ack and err asserted together -> rsp_err_o = 1 only.
REQ-042 Back-to-back reads 0x0018 then 0x0028 -> data 0x02804000000002a0 then 0x028680000004e200, rsp_valid_o 4 cycles apart; rst_i low in cycle 2 of the second read -> stb low immediately, no second response.
